// File: rtl/i2c_tof_target.sv
// I2C target emulating a ToF sensor register interface: START/STOP decode,
// 7-bit address match, 16-bit auto-incrementing register pointer, byte
// reads/writes, a fabric-loaded distance pair and an active-low interrupt.
module i2c_tof_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h11,
    parameter int         MEM_AW     = 8,
    parameter logic [7:0] DEVICE_ID  = 8'hEA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SDA_t,
    output logic        ToF_INT,
    input  logic [15:0] distance_in,
    input  logic        distance_valid,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]  sync1_reg, sync2_reg, prev_reg;
    logic        scl, sda, scl_rise, scl_fall, start_det, stop_det;

    state_t      state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  tx_reg, tx_next;
    logic [15:0] pointer_reg, pointer_next;
    logic        sda_t_reg, sda_t_next;
    logic        busy_reg, busy_next;
    logic        wr_strobe, load_byte;

    logic [7:0]  mem [0:(1<<MEM_AW)-1];
    logic [7:0]  mem_rd_reg;
    logic [7:0]  dist_hi_reg, dist_lo_reg, hold_reg;
    logic        hold_armed_reg, tof_int_reg;
    logic [7:0]  rd_byte;
    logic        is_special;

    // Two-flop synchronizers plus a previous-value stage for edge detection;
    // idle bus level is high so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
            prev_reg  <= 2'b11;
        end else begin
            sync1_reg <= {SDA_in, SCL_in};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign scl       = sync2_reg[0];
    assign sda       = sync2_reg[1];
    assign scl_rise  = scl & ~prev_reg[0];
    assign scl_fall  = ~scl & prev_reg[0];
    assign start_det = scl & prev_reg[0] & prev_reg[1] & ~sda;
    assign stop_det  = scl & prev_reg[0] & ~prev_reg[1] & sda;

    // Read data source for the byte at the current pointer.
    always_comb begin
        rd_byte = mem_rd_reg;
        case (pointer_reg)
            16'h0000: rd_byte = DEVICE_ID;
            16'h0010: rd_byte = dist_hi_reg;
            16'h0011: rd_byte = hold_armed_reg ? hold_reg : dist_lo_reg;
            16'h0012: rd_byte = {7'b0, ~tof_int_reg};
            default:  ;
        endcase
    end

    // Protocol state register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'h00;
            tx_reg      <= 8'h00;
            pointer_reg <= 16'h0000;
            sda_t_reg   <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            pointer_reg <= pointer_next;
            sda_t_reg   <= sda_t_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state logic: bits shift in on SCL rise, SDA only changes on SCL fall.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pointer_next = pointer_reg;
        sda_t_next   = sda_t_reg;
        busy_next    = busy_reg;
        wr_strobe    = 1'b0;
        load_byte    = 1'b0;
        if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            sda_t_next   = 1'b1;
        end else if (stop_det) begin
            state_next = IDLE;
            sda_t_next = 1'b1;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ADDR, PTR_HI, PTR_LO, WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = 4'd0;
                        sda_t_next   = 1'b0;
                        case (state_reg)
                            ADDR: begin
                                if (shift_reg[7:1] == SLAVE_ADDR) begin
                                    state_next = ADDR_ACK;
                                    busy_next  = 1'b1;
                                end else begin
                                    state_next = WAIT_STOP;
                                    sda_t_next = 1'b1;
                                    busy_next  = 1'b0;
                                end
                            end
                            PTR_HI: begin
                                pointer_next[15:8] = shift_reg;
                                state_next         = PTR_HI_ACK;
                            end
                            PTR_LO: begin
                                pointer_next[7:0] = shift_reg;
                                state_next        = PTR_LO_ACK;
                            end
                            default: begin
                                wr_strobe    = 1'b1;
                                pointer_next = pointer_reg + 16'd1;
                                state_next   = WR_ACK;
                            end
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_reg[0]) begin
                            state_next = RD_DATA;
                            load_byte  = 1'b1;
                            tx_next    = rd_byte;
                            sda_t_next = rd_byte[7];
                        end else begin
                            state_next = PTR_HI;
                            sda_t_next = 1'b1;
                        end
                    end
                end
                PTR_HI_ACK, PTR_LO_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_t_next = 1'b1;
                        state_next = (state_reg == PTR_HI_ACK) ? PTR_LO : WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next   = RD_ACK;
                            sda_t_next   = 1'b1;
                            bit_cnt_next = 4'd0;
                            pointer_next = pointer_reg + 16'd1;
                        end else begin
                            tx_next    = {tx_reg[6:0], 1'b0};
                            sda_t_next = tx_reg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda) begin
                        state_next = WAIT_STOP;
                    end else if (scl_fall) begin
                        state_next = RD_DATA;
                        load_byte  = 1'b1;
                        tx_next    = rd_byte;
                        sda_t_next = rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_special = (pointer_reg == 16'h0000) || (pointer_reg == 16'h0010) ||
                        (pointer_reg == 16'h0011) || (pointer_reg == 16'h0012);

    // General register storage with registered read; not reset.
    always_ff @(posedge clk) begin
        if (wr_strobe && !is_special)
            mem[pointer_reg[MEM_AW-1:0]] <= shift_reg;
        mem_rd_reg <= mem[pointer_reg[MEM_AW-1:0]];
    end

    // Distance registers, interrupt, and the low-byte snapshot for coherent reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_hi_reg    <= 8'h00;
            dist_lo_reg    <= 8'h00;
            hold_reg       <= 8'h00;
            hold_armed_reg <= 1'b0;
            tof_int_reg    <= 1'b1;
        end else begin
            if (distance_valid) begin
                dist_hi_reg <= distance_in[15:8];
                dist_lo_reg <= distance_in[7:0];
                tof_int_reg <= 1'b0;
            end else if (wr_strobe && pointer_reg == 16'h0012) begin
                tof_int_reg <= 1'b1;
            end
            if (start_det || stop_det) begin
                hold_armed_reg <= 1'b0;
            end else if (load_byte) begin
                hold_armed_reg <= (pointer_reg == 16'h0010);
                if (pointer_reg == 16'h0010)
                    hold_reg <= dist_lo_reg;
            end
        end
    end

    assign SDA_t   = sda_t_reg;
    assign busy    = busy_reg;
    assign ToF_INT = tof_int_reg;
endmodule

// File: tb/tb_i2c_tof_target.sv
// Bench for i2c_tof_target: bit-level I2C master driving an open-drain bus,
// checked against a register-map reference model.
module tb_i2c_tof_target;
    localparam int Q = 6;   // quarter SCL period in clk cycles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] distance_in = 16'h0000;
    logic        distance_valid = 1'b0;
    logic        SDA_t, ToF_INT, busy;
    logic        sda_line;

    assign sda_line = sda_m & SDA_t;

    i2c_tof_target dut (
        .clk(clk), .reset(reset), .SCL_in(scl_m), .SDA_in(sda_line),
        .SDA_t(SDA_t), .ToF_INT(ToF_INT), .distance_in(distance_in),
        .distance_valid(distance_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int low_cnt = 0;
    int busy_cnt = 0;

    // Activity counters used to prove the target stays off the bus.
    always @(negedge clk) begin
        if (!SDA_t) low_cnt <= low_cnt + 1;
        if (busy)   busy_cnt <= busy_cnt + 1;
    end

    // Reference model state
    logic [7:0]  m_mem [0:255];
    logic [15:0] m_ptr = 16'h0000;
    logic [15:0] m_dist = 16'h0000;
    logic        m_int = 1'b1;
    logic        m_last10 = 1'b0;
    logic [7:0]  m_hold = 8'h00;
    logic [7:0]  wq[$];

    function automatic void m_write(input logic [7:0] v);
        case (m_ptr)
            16'h0000, 16'h0010, 16'h0011: ;
            16'h0012: m_int = 1'b1;
            default:  m_mem[m_ptr[7:0]] = v;
        endcase
        m_ptr = m_ptr + 16'd1;
    endfunction

    function automatic logic [7:0] m_read();
        logic [7:0] v;
        case (m_ptr)
            16'h0000: v = 8'hEA;
            16'h0010: v = m_dist[15:8];
            16'h0011: v = m_last10 ? m_hold : m_dist[7:0];
            16'h0012: v = {7'b0, ~m_int};
            default:  v = m_mem[m_ptr[7:0]];
        endcase
        m_last10 = (m_ptr == 16'h0010);
        if (m_last10) m_hold = m_dist[7:0];
        m_ptr = m_ptr + 16'd1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic d, output logic s);
        wait_clk(Q); sda_m = d;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); s = sda_line;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic last, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            b = {b[6:0], s};
        end
        bit_cycle(last, s);
    endtask

    task automatic set_ptr(input logic [15:0] p);
        logic ack;
        i2c_start();
        send_byte(8'h22, ack); check("addr_w_ack", ack, 1'b1);
        send_byte(p[15:8], ack); check("ptr_hi_ack", ack, 1'b1);
        send_byte(p[7:0], ack);  check("ptr_lo_ack", ack, 1'b1);
        m_ptr = p;
    endtask

    task automatic wr_txn(input logic [15:0] p);
        logic ack;
        set_ptr(p);
        foreach (wq[i]) begin
            send_byte(wq[i], ack); check("wr_ack", ack, 1'b1);
            m_write(wq[i]);
        end
        i2c_stop();
        $display("[TB] write ptr=%04h bytes=%0d", p, wq.size());
    endtask

    task automatic rd_body(input int n);
        logic ack;
        logic [7:0] b;
        i2c_start();
        send_byte(8'h23, ack); check("addr_r_ack", ack, 1'b1);
        check("busy_after_ack", busy, 1'b1);
        m_last10 = 1'b0;
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            check("rd_data", b, m_read());
        end
        i2c_stop();
        check("sda_released_after_stop", SDA_t, 1'b1);
        check("busy_after_stop", busy, 1'b0);
    endtask

    task automatic rd_txn(input logic [15:0] p, input int n);
        set_ptr(p);
        rd_body(n);
        $display("[TB] read ptr=%04h bytes=%0d", p, n);
    endtask

    task automatic dv(input logic [15:0] v);
        distance_in = v; distance_valid = 1'b1;
        wait_clk(1);
        distance_valid = 1'b0;
        m_dist = v; m_int = 1'b0;
        check("tof_int_after_strobe", ToF_INT, 1'b0);
        $display("[TB] distance_valid %04h", v);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic [7:0] b;
        int lc, bc;
        logic [15:0] p;
        int n;

        wait_clk(4);
        check("rst_sda_t", SDA_t, 1'b1);
        check("rst_tof_int", ToF_INT, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_clk(4);
        $display("[TB] reset released");

        // Device ID read with repeated START
        rd_txn(16'h0000, 1);

        // Burst write and read-back; pointer continuation after the burst
        wq = {8'h5A}; wr_txn(16'h0043);
        wq = {8'hA1, 8'hB2, 8'hC3}; wr_txn(16'h0040);
        rd_txn(16'h0040, 3);
        check("ptr_end", m_ptr, 16'h0043);
        rd_body(1);
        $display("[TB] current-address read 1 byte");

        // Address mismatch: no ACK, bus untouched, not busy
        lc = low_cnt; bc = busy_cnt;
        i2c_start();
        send_byte(8'h30, ack); check("mismatch_nack", ack, 1'b0);
        send_byte(8'h55, ack); check("mismatch_data_nack", ack, 1'b0);
        i2c_stop();
        wait_clk(2);
        check("mismatch_sda_quiet", low_cnt - lc, 0);
        check("mismatch_not_busy", busy_cnt - bc, 0);
        $display("[TB] mismatched address 0x30");
        rd_txn(16'h0000, 1);

        // Interrupt and distance registers
        wait_clk(1);
        dv(16'h1234);
        rd_txn(16'h0010, 3);
        wq = {8'h00}; wr_txn(16'h0012);
        check("tof_int_cleared", ToF_INT, 1'b1);

        // Coherency: new sample between high and low byte
        set_ptr(16'h0010);
        i2c_start();
        send_byte(8'h23, ack); check("coh_addr_ack", ack, 1'b1);
        m_last10 = 1'b0;
        recv_byte(1'b0, b); check("coh_hi", b, m_read());
        wait_clk(2);
        dv(16'h5678);
        recv_byte(1'b1, b); check("coh_lo_snapshot", b, m_read());
        check("coh_lo_is_old", b, 8'h34);
        i2c_stop();
        $display("[TB] coherent read across distance update");
        rd_txn(16'h0010, 2);

        // Randomized write/read-back with interleaved distance samples
        for (int it = 0; it < 5; it++) begin
            p = 16'($urandom_range(16'h0020, 16'h00F0));
            n = $urandom_range(1, 4);
            wq = {};
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            wr_txn(p);
            if ($urandom_range(0, 1) == 1) begin
                wait_clk(1);
                dv(16'($urandom));
            end
            rd_txn(p, n);
            rd_txn(16'h0010, 3);
        end

        // Pointer wrap: second byte lands on the read-only ID
        wq = {8'h77, 8'h88}; wr_txn(16'hFFFF);
        check("wrap_ptr", m_ptr, 16'h0001);
        rd_txn(16'h0000, 1);
        rd_txn(16'hFFFF, 1);

        // Reset in the middle of a transfer while ACK is being driven
        dv(16'hBEEF);
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic s;
            bit_cycle(b[0] & 1'b0 | ((8'h22 >> i) & 8'h01) != 0, s);
        end
        wait_clk(Q);
        check("ack_driven_before_reset", SDA_t, 1'b0);
        check("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        wait_clk(1);
        check("midrst_sda_t", SDA_t, 1'b1);
        check("midrst_tof_int", ToF_INT, 1'b1);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        m_dist = 16'h0000; m_int = 1'b1; m_ptr = 16'h0000; m_hold = 8'h00; m_last10 = 1'b0;
        $display("[TB] reset asserted mid-transfer");
        i2c_stop();
        rd_txn(16'h0010, 3);
        rd_txn(16'h0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2c_tof_target.md
# i2c_tof_target

I2C target (responder) that emulates a ToF sensor's register interface at the far end of the sensor bus, so the per-sensor I2C master and ToF FSM can be exercised in simulation and on hardware loopback without real sensors. It decodes START/STOP, matches a 7-bit address, accepts a 16-bit register pointer and serves byte reads and writes from a small register file with pointer auto-increment. It exposes a result register pair loaded from the fabric side and signals new data on an active-low interrupt line.

## Interface
- SLAVE_ADDR, 7'h11, 7-bit target address matched in the address byte
- MEM_AW, 8, log2 of register-file depth; register index = pointer[MEM_AW-1:0]
- DEVICE_ID, 8'hEA, read-only value at register 0x0000

- clk  input  1  system clock; must be ≥ 8× SCL frequency
- reset  input  1  synchronous, active-high
- SCL_in  input  1  SCL pad value (from IOBUF output)
- SDA_in  input  1  SDA pad value (from IOBUF output)
- SDA_t  output  1  SDA tristate control: 1 = release (high-Z), 0 = drive low
- ToF_INT  output  1  active-low data-ready interrupt
- distance_in  input  16  new distance sample from fabric
- distance_valid  input  1  one-cycle strobe loading distance_in
- busy  output  1  high from matched address ACK until STOP or mismatched START

## Operation
- SCL_in/SDA_in pass through 2-flop synchronizers, then a registered previous-value for edge detection. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START in any state → ADDR, bit counter cleared (covers repeated START). STOP in any state → IDLE, SDA_t=1.
- ADDR: shift 8 bits MSB first on SCL rise. Match of [7:1] to SLAVE_ADDR → ADDR_ACK; mismatch → WAIT_STOP (no ACK, SDA untouched).
- After ACK: R/W=0 → PTR_HI; R/W=1 → RD_DATA.
- PTR_HI, PTR_LO: each byte ACKed, forms 16-bit pointer MSB first; then WR_DATA.
- WR_DATA: byte ACKed, written to register file at pointer, pointer += 1 (16-bit wrap 0xFFFF→0x0000; index aliases modulo 2^MEM_AW). Writes to 0x0000, 0x0010, 0x0011 ignored but ACKed. Any write to 0x0012 deasserts ToF_INT.
- RD_DATA: transmits byte at pointer MSB first, pointer += 1 after the byte. RD_ACK samples master bit: ACK (0) → next byte; NACK (1) → WAIT_STOP.
- Register map: 0x0000 DEVICE_ID; 0x0010 distance[15:8]; 0x0011 distance[7:0]; 0x0012 status, bit0 = ~ToF_INT; others general RW storage.
- Coherency: transmitting 0x0010 snapshots the current 0x0011 value into a hold register; an immediately following read of 0x0011 returns the snapshot.
- distance_valid: loads 0x0010/0x0011, asserts ToF_INT low. Same-cycle write to 0x0012 and distance_valid: ToF_INT stays low.

## Timing
- Reset values: SDA_t=1, ToF_INT=1, busy=0, state IDLE, pointer 0x0000, distance regs 0x0000, hold 0x00. General register storage not reset.
- Edge detect latency: 3 clk from pad change to internal event.
- Data bits sampled on detected SCL rise. SDA_t changes only on detected SCL fall: driven low for ACK after the 8th fall, released after the 9th fall; read data bit n driven after the fall preceding its SCL high phase; released after the 8th data bit's fall for the master ACK slot.
- distance_valid visible at register read and ToF_INT 1 clk after the strobe.
- reset mid-transfer: immediate return to IDLE with SDA released; the master sees NACK/bus-high.

## Test plan
- Read ID: START, 0x22, ptr 0x0000, rSTART, 0x23, read 1 byte, NACK, STOP → three ACKs, data 0xEA, SDA released after STOP.
- Burst write/read: write 0xA1,0xB2,0xC3 at 0x0040; read 3 from 0x0040 → 0xA1,0xB2,0xC3; pointer ends at 0x0043.
- Address mismatch: address byte 0x30 → no ACK, SDA_t=1 throughout, busy=0; following valid transfer succeeds.
- Interrupt: distance_valid with 0x1234 → ToF_INT=0 next clk, read 0x0010..0x0012 → 0x12,0x34,0x01; write 0x00 to 0x0012 → ToF_INT=1.
- Coherency: start reading 0x0010 (value 0x1234), pulse distance_valid 0x5678 between bytes → bytes 0x12,0x34; next read → 0x56,0x78.
- Wrap and reset: write at 0xFFFF two bytes → second lands at 0x0000 (ignored, ID still 0xEA); assert reset mid-byte → SDA_t=1, ToF_INT=1, busy=0 next clk.
